// File: rtl/amax10_qsys_mem_pkg.sv
// Shared types and sizes for the two-master on-chip RAM arbiter.
// Combinational grant, one access per clock, one-cycle read return.
package amax10_qsys_mem_pkg;

  localparam int MASTER_ID_W = 1;
  localparam int MEM_ADDR_W  = 15;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_BE_W    = MEM_DATA_W / 8;
  localparam int MEM_DEPTH   = 32500;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] address;
    logic [MEM_BE_W-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [MEM_DATA_W-1:0] writedata;
  } avmm_cmd_t;

endpackage

// File: rtl/amax10_qsys_rr_arb2.sv
// Two-requester grant logic: round-robin pointer or fixed priority with an m1 starvation bound.
// Grant is combinational from the requests; pointer and hold counter update at the clock edge.
module amax10_qsys_rr_arb2
  import amax10_qsys_mem_pkg::*;
#(
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   req0_i,
  input  logic                   req1_i,
  output logic                   gnt_vld_o,
  output logic [MASTER_ID_W-1:0] gnt_id_o
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [MASTER_ID_W-1:0] rr_last_q, rr_last_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;

  always_comb begin
    gnt_vld_o = req0_i | req1_i;
    gnt_id_o  = '0;
    if (req0_i && req1_i) begin
      if (RR_EN != 0) gnt_id_o = ~rr_last_q;
      else            gnt_id_o = (hold_cnt_q == HOLD_W'(MAX_HOLD));
    end else if (req1_i) begin
      gnt_id_o = 1'b1;
    end
  end

  always_comb begin
    rr_last_d  = rr_last_q;
    hold_cnt_d = hold_cnt_q;
    if (gnt_vld_o) rr_last_d = gnt_id_o;
    // Counts only m0 wins that leave m1 waiting; any m1 grant or m1 idle restarts the window.
    if (!req1_i || (gnt_vld_o && gnt_id_o == 1'b1)) begin
      hold_cnt_d = '0;
    end else if (gnt_vld_o && hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_last_q  <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/amax10_qsys_onchip_memory2_arbiter.sv
// Two-master Avalon-MM arbiter for the single-port on-chip RAM: one access per clock,
// read data returned one cycle after grant; the losing master is held off with waitrequest.
module amax10_qsys_onchip_memory2_arbiter
  import amax10_qsys_mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int DEPTH    = MEM_DEPTH,
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic [DATA_W/8-1:0] m0_byteenable_i,
  input  logic                m0_read_i,
  input  logic                m0_write_i,
  input  logic [DATA_W-1:0]   m0_writedata_i,
  output logic                m0_waitrequest_o,
  output logic [DATA_W-1:0]   m0_readdata_o,
  output logic                m0_readdatavalid_o,
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic [DATA_W/8-1:0] m1_byteenable_i,
  input  logic                m1_read_i,
  input  logic                m1_write_i,
  input  logic [DATA_W-1:0]   m1_writedata_i,
  output logic                m1_waitrequest_o,
  output logic [DATA_W-1:0]   m1_readdata_o,
  output logic                m1_readdatavalid_o,
  output logic [ADDR_W-1:0]   mem_address_o,
  output logic [DATA_W/8-1:0] mem_byteenable_o,
  output logic                mem_chipselect_o,
  output logic                mem_write_o,
  output logic [DATA_W-1:0]   mem_writedata_o,
  output logic                mem_clken_o,
  input  logic [DATA_W-1:0]   mem_readdata_i,
  output logic [15:0]         oor_count_o
);

  localparam logic [31:0] DEPTH_U = DEPTH;

  avmm_cmd_t              cmd0, cmd1, sel;
  logic                   req0, req1;
  logic                   gnt_vld;
  logic [MASTER_ID_W-1:0] gnt_id;
  logic                   oor;
  logic                   gnt_rd;

  logic                   rd_pend_q, rd_pend_d;
  logic [MASTER_ID_W-1:0] rd_owner_q, rd_owner_d;
  logic                   rd_oor_q, rd_oor_d;
  logic [15:0]            oor_count_q, oor_count_d;
  logic [DATA_W-1:0]      rd_data;

  assign cmd0 = '{address: m0_address_i, byteenable: m0_byteenable_i, read: m0_read_i,
                  write: m0_write_i, writedata: m0_writedata_i};
  assign cmd1 = '{address: m1_address_i, byteenable: m1_byteenable_i, read: m1_read_i,
                  write: m1_write_i, writedata: m1_writedata_i};

  // Requests are masked in reset so nothing is granted and both masters see waitrequest.
  assign req0 = reset_n_i & (m0_read_i | m0_write_i);
  assign req1 = reset_n_i & (m1_read_i | m1_write_i);

  amax10_qsys_rr_arb2 #(
    .RR_EN    (RR_EN),
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .req0_i    (req0),
    .req1_i    (req1),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  assign sel    = (gnt_id == 1'b1) ? cmd1 : cmd0;
  assign oor    = gnt_vld && (32'(sel.address) >= DEPTH_U);
  // Read and write together is treated as a write.
  assign gnt_rd = gnt_vld && sel.read && !sel.write;

  assign m0_waitrequest_o = !(gnt_vld && gnt_id == 1'b0);
  assign m1_waitrequest_o = !(gnt_vld && gnt_id == 1'b1);

  assign mem_address_o    = sel.address;
  assign mem_byteenable_o = sel.byteenable;
  assign mem_writedata_o  = sel.writedata;
  assign mem_chipselect_o = gnt_vld && !oor;
  assign mem_write_o      = gnt_vld && !oor && sel.write;
  assign mem_clken_o      = 1'b1;

  always_comb begin
    rd_pend_d   = gnt_rd;
    rd_owner_d  = gnt_id;
    rd_oor_d    = oor;
    oor_count_d = oor_count_q;
    if (oor && oor_count_q != 16'hFFFF) oor_count_d = oor_count_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= '0;
      rd_oor_q    <= 1'b0;
      oor_count_q <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      rd_oor_q    <= rd_oor_d;
      oor_count_q <= oor_count_d;
    end
  end

  // Gating with reset_n drops a return that lands in a reset cycle.
  assign rd_data            = rd_oor_q ? '0 : mem_readdata_i;
  assign m0_readdata_o      = rd_data;
  assign m1_readdata_o      = rd_data;
  assign m0_readdatavalid_o = reset_n_i && rd_pend_q && rd_owner_q == 1'b0;
  assign m1_readdatavalid_o = reset_n_i && rd_pend_q && rd_owner_q == 1'b1;
  assign oor_count_o        = oor_count_q;

endmodule

// File: tb/tb_amax10_qsys_onchip_memory2_arbiter.sv
// Directed bench: round-robin instance (a) and fixed-priority instance (b) share master stimulus,
// each backed by its own behavioural single-port RAM with one-cycle read latency.
module tb_amax10_qsys_onchip_memory2_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;

  logic        a_m0_wait, a_m0_rdv, a_m1_wait, a_m1_rdv;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic [14:0] a_mem_addr;
  logic [3:0]  a_mem_be;
  logic        a_mem_cs, a_mem_we, a_mem_clken;
  logic [31:0] a_mem_wd, a_mem_rdata;
  logic [15:0] a_oor;

  logic        b_m0_wait, b_m0_rdv, b_m1_wait, b_m1_rdv;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic [14:0] b_mem_addr;
  logic [3:0]  b_mem_be;
  logic        b_mem_cs, b_mem_we, b_mem_clken;
  logic [31:0] b_mem_wd, b_mem_rdata;
  logic [15:0] b_oor;

  logic [31:0] ram_a [0:32499];
  logic [31:0] ram_b [0:32499];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  amax10_qsys_onchip_memory2_arbiter #(.RR_EN(1), .MAX_HOLD(8)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n),
    .m0_address_i(m0_address), .m0_byteenable_i(m0_byteenable), .m0_read_i(m0_read),
    .m0_write_i(m0_write), .m0_writedata_i(m0_writedata), .m0_waitrequest_o(a_m0_wait),
    .m0_readdata_o(a_m0_rdata), .m0_readdatavalid_o(a_m0_rdv),
    .m1_address_i(m1_address), .m1_byteenable_i(m1_byteenable), .m1_read_i(m1_read),
    .m1_write_i(m1_write), .m1_writedata_i(m1_writedata), .m1_waitrequest_o(a_m1_wait),
    .m1_readdata_o(a_m1_rdata), .m1_readdatavalid_o(a_m1_rdv),
    .mem_address_o(a_mem_addr), .mem_byteenable_o(a_mem_be), .mem_chipselect_o(a_mem_cs),
    .mem_write_o(a_mem_we), .mem_writedata_o(a_mem_wd), .mem_clken_o(a_mem_clken),
    .mem_readdata_i(a_mem_rdata), .oor_count_o(a_oor)
  );

  amax10_qsys_onchip_memory2_arbiter #(.RR_EN(0), .MAX_HOLD(8)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .m0_address_i(m0_address), .m0_byteenable_i(m0_byteenable), .m0_read_i(m0_read),
    .m0_write_i(m0_write), .m0_writedata_i(m0_writedata), .m0_waitrequest_o(b_m0_wait),
    .m0_readdata_o(b_m0_rdata), .m0_readdatavalid_o(b_m0_rdv),
    .m1_address_i(m1_address), .m1_byteenable_i(m1_byteenable), .m1_read_i(m1_read),
    .m1_write_i(m1_write), .m1_writedata_i(m1_writedata), .m1_waitrequest_o(b_m1_wait),
    .m1_readdata_o(b_m1_rdata), .m1_readdatavalid_o(b_m1_rdv),
    .mem_address_o(b_mem_addr), .mem_byteenable_o(b_mem_be), .mem_chipselect_o(b_mem_cs),
    .mem_write_o(b_mem_we), .mem_writedata_o(b_mem_wd), .mem_clken_o(b_mem_clken),
    .mem_readdata_i(b_mem_rdata), .oor_count_o(b_oor)
  );

  always @(posedge clk) begin
    if (a_mem_clken && a_mem_cs) begin
      for (int i = 0; i < 4; i++)
        if (a_mem_we && a_mem_be[i]) ram_a[a_mem_addr][8*i +: 8] <= a_mem_wd[8*i +: 8];
      a_mem_rdata <= ram_a[a_mem_addr];
    end
  end

  always @(posedge clk) begin
    if (b_mem_clken && b_mem_cs) begin
      for (int i = 0; i < 4; i++)
        if (b_mem_we && b_mem_be[i]) ram_b[b_mem_addr][8*i +: 8] <= b_mem_wd[8*i +: 8];
      b_mem_rdata <= ram_b[b_mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  task automatic do_reset();
    step(); idle(); reset_n = 1'b0;
    step(); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    m0_read = 1'b1; m0_address = 15'd5;
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      n_cmp++; if (a_m0_wait !== 1'b1) begin n_bad++; $display("FAIL rst_wait got=%b exp=1", a_m0_wait); end
      n_cmp++; if (a_m0_rdv !== 1'b0) begin n_bad++; $display("FAIL rst_rdv got=%b exp=0", a_m0_rdv); end
      n_cmp++; if (a_mem_cs !== 1'b0) begin n_bad++; $display("FAIL rst_cs got=%b exp=0", a_mem_cs); end
      n_cmp++; if (a_mem_clken !== 1'b1) begin n_bad++; $display("FAIL rst_clken got=%b exp=1", a_mem_clken); end
      n_cmp++; if (a_oor !== 16'd0) begin n_bad++; $display("FAIL rst_oor got=%0d exp=0", a_oor); end
    end
    m0_read = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic preload();
    step(); m0_write = 1'b1; m0_byteenable = 4'hF; m0_address = 15'd1;     m0_writedata = 32'h1111_0001;
    step(); m0_address = 15'd2;     m0_writedata = 32'h2222_0002;
    step(); m0_address = 15'd32499; m0_writedata = 32'hDEAD_BEEF;
    step(); m0_address = 15'd32;    m0_writedata = 32'h0000_0000;
    step(); m0_write = 1'b0;
  endtask

  task automatic test_single_master();
    step(); m0_write = 1'b1; m0_address = 15'h0010; m0_byteenable = 4'hF; m0_writedata = 32'hA5A5_1234;
    #1;
    n_cmp++; if (a_m0_wait !== 1'b0) begin n_bad++; $display("FAIL sm_wr_wait got=%b exp=0", a_m0_wait); end
    n_cmp++; if (a_mem_we !== 1'b1 || a_mem_cs !== 1'b1) begin n_bad++; $display("FAIL sm_wr_strobe got=%b%b exp=11", a_mem_cs, a_mem_we); end
    n_cmp++; if (a_mem_addr !== 15'h0010) begin n_bad++; $display("FAIL sm_wr_addr got=%h exp=0010", a_mem_addr); end
    step(); m0_write = 1'b0; m0_read = 1'b1;
    #1;
    n_cmp++; if (a_m0_wait !== 1'b0) begin n_bad++; $display("FAIL sm_rd_wait got=%b exp=0", a_m0_wait); end
    n_cmp++; if (a_m0_rdv !== 1'b0) begin n_bad++; $display("FAIL sm_rdv_early got=%b exp=0", a_m0_rdv); end
    step(); m0_read = 1'b0;
    #1;
    n_cmp++; if (a_m0_rdv !== 1'b1) begin n_bad++; $display("FAIL sm_rdv got=%b exp=1", a_m0_rdv); end
    n_cmp++; if (a_m0_rdata !== 32'hA5A5_1234) begin n_bad++; $display("FAIL sm_rdata got=%h exp=a5a51234", a_m0_rdata); end
    n_cmp++; if (a_m1_rdv !== 1'b0) begin n_bad++; $display("FAIL sm_m1_rdv got=%b exp=0", a_m1_rdv); end
    step(); #1;
    n_cmp++; if (a_m0_rdv !== 1'b0) begin n_bad++; $display("FAIL sm_rdv_extra got=%b exp=0", a_m0_rdv); end
  endtask

  task automatic test_conflict_rr();
    logic exp_g, prev_g;
    int   cnt0, cnt1;
    cnt0 = 0; cnt1 = 0;
    do_reset();
    m0_read = 1'b1; m0_address = 15'd1; m1_read = 1'b1; m1_address = 15'd2;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        step();
        if (i == 6) idle();
      end
      #1;
      if (i > 0) begin
        prev_g = (((i - 1) % 2) == 1);
        cnt0 += int'(a_m0_rdv); cnt1 += int'(a_m1_rdv);
        n_cmp++; if (a_m0_rdv !== !prev_g || a_m1_rdv !== prev_g) begin n_bad++; $display("FAIL rr_rdv[%0d] got=%b%b exp_owner=%b", i, a_m0_rdv, a_m1_rdv, prev_g); end
        n_cmp++; if (a_m0_rdata !== (prev_g ? 32'h2222_0002 : 32'h1111_0001)) begin n_bad++; $display("FAIL rr_rdata[%0d] got=%h owner=%b", i, a_m0_rdata, prev_g); end
      end
      if (i < 6) begin
        exp_g = ((i % 2) == 1);
        n_cmp++; if (a_m0_wait !== exp_g || a_m1_wait !== !exp_g) begin n_bad++; $display("FAIL rr_grant[%0d] got_wait=%b%b exp_gnt=%b", i, a_m0_wait, a_m1_wait, exp_g); end
        n_cmp++; if (a_mem_addr !== (exp_g ? 15'd2 : 15'd1)) begin n_bad++; $display("FAIL rr_addr[%0d] got=%0d", i, a_mem_addr); end
      end
    end
    step(); #1;
    n_cmp++; if (a_m0_rdv !== 1'b0 || a_m1_rdv !== 1'b0) begin n_bad++; $display("FAIL rr_rdv_tail got=%b%b exp=00", a_m0_rdv, a_m1_rdv); end
    n_cmp++; if (cnt0 != 3 || cnt1 != 3) begin n_bad++; $display("FAIL rr_counts got=%0d/%0d exp=3/3", cnt0, cnt1); end
  endtask

  task automatic test_fixed_priority();
    logic exp_g;
    int   run, max_run;
    run = 0; max_run = 0;
    do_reset();
    m0_read = 1'b1; m0_address = 15'd1; m1_read = 1'b1; m1_address = 15'd2;
    for (int i = 0; i < 27; i++) begin
      if (i > 0) step();
      #1;
      exp_g = ((i % 9) == 8);
      n_cmp++; if (b_m0_wait !== exp_g || b_m1_wait !== !exp_g) begin n_bad++; $display("FAIL fp_grant[%0d] got_wait=%b%b exp_gnt=%b", i, b_m0_wait, b_m1_wait, exp_g); end
      if (b_m1_wait) run++; else run = 0;
      if (run > max_run) max_run = run;
    end
    step(); idle(); #1;
    n_cmp++; if (b_m1_rdv !== 1'b1 || b_m1_rdata !== 32'h2222_0002) begin n_bad++; $display("FAIL fp_m1_return got=%b/%h exp=1/22220002", b_m1_rdv, b_m1_rdata); end
    n_cmp++; if (max_run != 8) begin n_bad++; $display("FAIL fp_max_wait got=%0d exp=8", max_run); end
  endtask

  task automatic test_out_of_range();
    step(); m1_write = 1'b1; m1_address = 15'd32500; m1_byteenable = 4'hF; m1_writedata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (a_m1_wait !== 1'b0) begin n_bad++; $display("FAIL oor_wr_wait got=%b exp=0", a_m1_wait); end
    n_cmp++; if (a_mem_cs !== 1'b0 || a_mem_we !== 1'b0) begin n_bad++; $display("FAIL oor_wr_strobe got=%b%b exp=00", a_mem_cs, a_mem_we); end
    step(); m1_write = 1'b0; m1_read = 1'b1;
    #1;
    n_cmp++; if (a_oor !== 16'd1) begin n_bad++; $display("FAIL oor_cnt1 got=%0d exp=1", a_oor); end
    n_cmp++; if (a_mem_cs !== 1'b0) begin n_bad++; $display("FAIL oor_rd_cs got=%b exp=0", a_mem_cs); end
    step(); m1_read = 1'b0;
    #1;
    n_cmp++; if (a_m1_rdv !== 1'b1 || a_m1_rdata !== 32'h0) begin n_bad++; $display("FAIL oor_rdata got=%b/%h exp=1/00000000", a_m1_rdv, a_m1_rdata); end
    n_cmp++; if (a_oor !== 16'd2) begin n_bad++; $display("FAIL oor_cnt2 got=%0d exp=2", a_oor); end
    n_cmp++; if (ram_a[32499] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL oor_ram32499 got=%h exp=deadbeef", ram_a[32499]); end
  endtask

  task automatic test_byte_lanes_reset();
    step(); m0_write = 1'b1; m0_address = 15'd32; m0_byteenable = 4'b0101; m0_writedata = 32'h1122_3344;
    step(); m0_write = 1'b0; m0_read = 1'b1;
    #1;
    n_cmp++; if (ram_a[32] !== 32'h0022_0044) begin n_bad++; $display("FAIL be_ram got=%h exp=00220044", ram_a[32]); end
    n_cmp++; if (a_m0_wait !== 1'b0) begin n_bad++; $display("FAIL be_rd_wait got=%b exp=0", a_m0_wait); end
    step();
    #1;
    n_cmp++; if (a_m0_rdv !== 1'b1 || a_m0_rdata !== 32'h0022_0044) begin n_bad++; $display("FAIL be_rdata got=%b/%h exp=1/00220044", a_m0_rdv, a_m0_rdata); end
    step(); reset_n = 1'b0; m0_read = 1'b0;
    #1;
    n_cmp++; if (a_m0_rdv !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rdv got=%b exp=0", a_m0_rdv); end
    step(); reset_n = 1'b1;
    #1;
    n_cmp++; if (a_m0_rdv !== 1'b0) begin n_bad++; $display("FAIL post_rst_rdv got=%b exp=0", a_m0_rdv); end
    n_cmp++; if (a_oor !== 16'd0) begin n_bad++; $display("FAIL post_rst_oor got=%0d exp=0", a_oor); end
    step(); #1;
    n_cmp++; if (a_m0_rdv !== 1'b0 || a_m1_rdv !== 1'b0) begin n_bad++; $display("FAIL late_rdv got=%b%b exp=00", a_m0_rdv, a_m1_rdv); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    idle();
    test_reset();
    preload();
    test_single_master();
    test_conflict_rr();
    test_fixed_priority();
    test_out_of_range();
    test_byte_lanes_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
